// File: rtl/dmem_pkg.sv
// Shared types and helpers for the datamem requester controller.
// The RMW datapath is selected with DMEM_ACCESS_CTRL_RMW_EN.
package dmem_pkg;

  localparam int DMEM_ADDR_BITS  = 16;
  localparam int DMEM_XY_BITS    = DMEM_ADDR_BITS / 2;
  localparam int DMEM_DATA_WIDTH = 64;
  localparam int DMEM_NBYTES     = DMEM_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } dmem_state_t;

  typedef struct packed {
    logic [DMEM_XY_BITS-1:0] x;
    logic [DMEM_XY_BITS-1:0] y;
  } dmem_xy_t;

  // Row comes from the upper half of the flat address, column from the lower half.
  function automatic dmem_xy_t dmem_xy_split(input logic [DMEM_ADDR_BITS-1:0] addr);
    dmem_xy_t xy;
    xy.x = addr[DMEM_ADDR_BITS-1:DMEM_XY_BITS];
    xy.y = addr[DMEM_XY_BITS-1:0];
    return xy;
  endfunction

endpackage

// File: rtl/dmem_byte_merge.sv
// Per-byte select between store data and the word read back from memory.
// Only instantiated when DMEM_ACCESS_CTRL_RMW_EN is defined.
module dmem_byte_merge
  import dmem_pkg::*;
#(
  parameter int NBYTES = DMEM_NBYTES
) (
  input  logic [NBYTES*8-1:0] wdata,
  input  logic [NBYTES*8-1:0] rdata,
  input  logic [NBYTES-1:0]   be,
  output logic [NBYTES*8-1:0] merged
);

  // Byte i follows wdata when its enable is set, otherwise keeps the memory byte.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller for the X/Y-addressed datamem, one request in flight.
// Define DMEM_ACCESS_CTRL_RMW_EN to honour req_be via read-modify-write.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS  = DMEM_ADDR_BITS,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    WriteEnable,
  output logic [ADDR_BITS/2-1:0]  X_addr,
  output logic [ADDR_BITS/2-1:0]  Y_addr,
  output logic [DATA_WIDTH-1:0]   Data_in,
  input  logic [DATA_WIDTH-1:0]   Data_out
);

  localparam int HALF   = ADDR_BITS / 2;
  localparam int NBYTES = DATA_WIDTH / 8;

  dmem_state_t             state_r, state_nxt_s;
  logic                    write_r;
  logic                    req_ready_r, resp_valid_r, we_r;
  logic [HALF-1:0]         x_addr_r, y_addr_r, x_nxt_s, y_nxt_s;
  logic [DATA_WIDTH-1:0]   data_r, data_in_r, cap_word_s;
  logic                    accept_s;

  assign accept_s    = (state_r == ST_IDLE) && req_valid;
  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_rdata  = data_r;
  assign X_addr      = x_addr_r;
  assign Y_addr      = y_addr_r;
  assign Data_in     = data_in_r;
  // A reset landing in WR must suppress the write on that same edge.
  assign WriteEnable = we_r && !Reset;

  generate
    if (ADDR_BITS == DMEM_ADDR_BITS) begin : g_pkg_split
      dmem_xy_t xy_s;
      assign xy_s    = dmem_xy_split(req_addr);
      assign x_nxt_s = xy_s.x;
      assign y_nxt_s = xy_s.y;
    end else begin : g_slice_split
      assign x_nxt_s = req_addr[ADDR_BITS-1:HALF];
      assign y_nxt_s = req_addr[HALF-1:0];
    end
  endgenerate

`ifdef DMEM_ACCESS_CTRL_RMW_EN
  logic [DATA_WIDTH-1:0] wdata_r, merged_s;
  logic [NBYTES-1:0]     be_r;

  dmem_byte_merge #(.NBYTES(NBYTES)) u_merge (
    .wdata  (wdata_r),
    .rdata  (Data_out),
    .be     (be_r),
    .merged (merged_s)
  );

  assign cap_word_s = write_r ? merged_s : Data_out;

  // Store operands kept for the merge in CAP.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wdata_r <= {DATA_WIDTH{1'b0}};
      be_r    <= {NBYTES{1'b0}};
    end else if (accept_s) begin
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end
  end
`else
  logic unused_be_s;
  assign unused_be_s = ^req_be;
  assign cap_word_s  = Data_out;
`endif

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_write) begin
            state_nxt_s = ST_RD;
          end else begin
`ifdef DMEM_ACCESS_CTRL_RMW_EN
            if (req_be == {NBYTES{1'b1}}) begin
              state_nxt_s = ST_WR;
            end else if (req_be == {NBYTES{1'b0}}) begin
              state_nxt_s = ST_RESP;
            end else begin
              state_nxt_s = ST_RD;
            end
`else
            state_nxt_s = ST_WR;
`endif
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:   state_nxt_s = ST_CAP;
      ST_CAP: begin
        if (write_r) begin
          state_nxt_s = ST_WR;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_WR:   state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, registered handshake/strobe outputs, address and data registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      we_r         <= 1'b0;
      write_r      <= 1'b0;
      x_addr_r     <= {HALF{1'b0}};
      y_addr_r     <= {HALF{1'b0}};
      data_r       <= {DATA_WIDTH{1'b0}};
      data_in_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      resp_valid_r <= (state_nxt_s == ST_RESP);
      we_r         <= (state_nxt_s == ST_WR);
      if (accept_s) begin
        write_r  <= req_write;
        x_addr_r <= x_nxt_s;
        y_addr_r <= y_nxt_s;
        if (req_write) begin
          data_in_r <= req_wdata;
`ifdef DMEM_ACCESS_CTRL_RMW_EN
          data_r <= (req_be == {NBYTES{1'b0}}) ? {DATA_WIDTH{1'b0}} : req_wdata;
`else
          data_r <= req_wdata;
`endif
        end
      end else if (state_r == ST_CAP) begin
        data_r    <= cap_word_s;
        data_in_r <= cap_word_s;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural one-cycle datamem.
// Expectations follow the build: DMEM_ACCESS_CTRL_RMW_EN defined or not.
module tb_dmem_access_ctrl;

`ifdef DMEM_ACCESS_CTRL_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [63:0] req_wdata = 64'h0;
  logic [7:0]  req_be = 8'h00;
  logic        req_ready, resp_valid, WriteEnable;
  logic [63:0] resp_rdata, Data_in;
  logic [63:0] Data_out = 64'h0;
  logic [7:0]  X_addr, Y_addr;

  logic [63:0] mem [0:65535];
  int total = 0;
  int bad = 0;

  dmem_access_ctrl dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .WriteEnable(WriteEnable), .X_addr(X_addr), .Y_addr(Y_addr),
    .Data_in(Data_in), .Data_out(Data_out)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (WriteEnable) mem[{X_addr, Y_addr}] <= Data_in;
    Data_out <= mem[{X_addr, Y_addr}];
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          lat;
    logic [63:0] rdata;
    int          we_lat;   // 0 = no write expected
    logic [63:0] we_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, we_cnt, we_lat;
    logic [63:0] we_data;
    logic [7:0] we_x, we_y;
    string tag;
    tag = $sformatf("v%0d", idx);
    chk({tag, ".req_ready"}, {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_be = v.be;
    tick();
    req_valid = 1'b0;
    lat = 1; we_cnt = 0; we_lat = 0; we_data = 64'h0; we_x = 8'h0; we_y = 8'h0;
    while (lat < 20) begin
      if (WriteEnable) begin
        we_cnt++; we_lat = lat; we_data = Data_in; we_x = X_addr; we_y = Y_addr;
      end
      if (resp_valid) break;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(v.lat));
    chk({tag, ".rdata"}, resp_rdata, v.rdata);
    chk({tag, ".we_count"}, 64'(we_cnt), (v.we_lat != 0) ? 64'h1 : 64'h0);
    if (v.we_lat != 0) begin
      chk({tag, ".we_cycle"}, 64'(we_lat), 64'(v.we_lat));
      chk({tag, ".we_data"}, we_data, v.we_data);
      chk({tag, ".we_x"}, {56'h0, we_x}, {56'h0, v.addr[15:8]});
      chk({tag, ".we_y"}, {56'h0, we_y}, {56'h0, v.addr[7:0]});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic wr, input logic [15:0] a, input logic [63:0] wd,
                         input logic [7:0] be, input int lat, input logic [63:0] rd,
                         input int wl, input logic [63:0] wdat);
    vecs[i].wr = wr; vecs[i].addr = a; vecs[i].wdata = wd; vecs[i].be = be;
    vecs[i].lat = lat; vecs[i].rdata = rd; vecs[i].we_lat = wl; vecs[i].we_data = wdat;
  endtask

  initial begin
    vec_t v;
    logic [63:0] held;
    int wait_cnt;
    for (int i = 0; i < 65536; i++) mem[i] = 64'h0;

    set_vec(0, 1'b1, 16'h1234, 64'hDEADBEEF_CAFEF00D, 8'hFF, 2, 64'hDEADBEEF_CAFEF00D, 1, 64'hDEADBEEF_CAFEF00D);
    set_vec(1, 1'b0, 16'h1234, 64'h0, 8'h00, 3, 64'hDEADBEEF_CAFEF00D, 0, 64'h0);
    set_vec(2, 1'b1, 16'h0001, 64'h11223344_55667788, 8'hFF, 2, 64'h11223344_55667788, 1, 64'h11223344_55667788);
    if (RMW)
      set_vec(3, 1'b1, 16'h0001, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 4, 64'h11223344_BBBBBBBB, 3, 64'h11223344_BBBBBBBB);
    else
      set_vec(3, 1'b1, 16'h0001, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 2, 64'hAAAAAAAA_BBBBBBBB, 1, 64'hAAAAAAAA_BBBBBBBB);
    set_vec(4, 1'b0, 16'h0001, 64'h0, 8'h00, 3, RMW ? 64'h11223344_BBBBBBBB : 64'hAAAAAAAA_BBBBBBBB, 0, 64'h0);
    if (RMW)
      set_vec(5, 1'b1, 16'h0002, 64'h01234567_89ABCDEF, 8'h00, 1, 64'h0, 0, 64'h0);
    else
      set_vec(5, 1'b1, 16'h0002, 64'h01234567_89ABCDEF, 8'h00, 2, 64'h01234567_89ABCDEF, 1, 64'h01234567_89ABCDEF);
    set_vec(6, 1'b0, 16'h0002, 64'h0, 8'h00, 3, RMW ? 64'h0 : 64'h01234567_89ABCDEF, 0, 64'h0);
    if (RMW)
      set_vec(7, 1'b1, 16'h0003, 64'hFFEEDDCC_BBAA9988, 8'h01, 4, 64'h00000000_00000088, 3, 64'h00000000_00000088);
    else
      set_vec(7, 1'b1, 16'h0003, 64'hFFEEDDCC_BBAA9988, 8'h01, 2, 64'hFFEEDDCC_BBAA9988, 1, 64'hFFEEDDCC_BBAA9988);
    set_vec(8, 1'b0, 16'h0003, 64'h0, 8'h00, 3, RMW ? 64'h00000000_00000088 : 64'hFFEEDDCC_BBAA9988, 0, 64'h0);
    set_vec(9, 1'b1, 16'hFF00, 64'h0F0F0F0F_F0F0F0F0, 8'hFF, 2, 64'h0F0F0F0F_F0F0F0F0, 1, 64'h0F0F0F0F_F0F0F0F0);
    if (RMW)
      set_vec(10, 1'b1, 16'hFF00, 64'h55000000_00000000, 8'h80, 4, 64'h550F0F0F_F0F0F0F0, 3, 64'h550F0F0F_F0F0F0F0);
    else
      set_vec(10, 1'b1, 16'hFF00, 64'h55000000_00000000, 8'h80, 2, 64'h55000000_00000000, 1, 64'h55000000_00000000);
    set_vec(11, 1'b0, 16'hFF00, 64'h0, 8'h00, 3, RMW ? 64'h550F0F0F_F0F0F0F0 : 64'h55000000_00000000, 0, 64'h0);

    tick(); tick();
    Reset = 1'b0;
    chk("rst.req_ready", {63'h0, req_ready}, 64'h1);
    chk("rst.resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("rst.we", {63'h0, WriteEnable}, 64'h0);
    chk("rst.xy", {48'h0, X_addr, Y_addr}, 64'h0);
    chk("rst.data_in", Data_in, 64'h0);
    chk("rst.rdata", resp_rdata, 64'h0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Response stall on a load of 0x1234.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234;
    tick();
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!resp_valid && wait_cnt < 20) begin tick(); wait_cnt++; end
    chk("stall.resp_seen", {63'h0, resp_valid}, 64'h1);
    held = resp_rdata;
    chk("stall.rdata", held, 64'hDEADBEEF_CAFEF00D);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall.resp_valid", {63'h0, resp_valid}, 64'h1);
      chk("stall.rdata_hold", resp_rdata, 64'hDEADBEEF_CAFEF00D);
      chk("stall.req_ready", {63'h0, req_ready}, 64'h0);
      chk("stall.we", {63'h0, WriteEnable}, 64'h0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("stall.back_idle", {62'h0, req_ready, resp_valid}, 64'h2);

    // Reset during the WR cycle of a full store to 0x00FF.
    mem[16'h00FF] = 64'hA5A5A5A5_5A5A5A5A;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h00FF;
    req_wdata = 64'h0BADF00D_0BADF00D; req_be = 8'hFF;
    tick();
    req_valid = 1'b0;
    chk("rstwr.in_wr", {63'h0, WriteEnable}, 64'h1);
    Reset = 1'b1;
    #1;
    chk("rstwr.we_gated", {63'h0, WriteEnable}, 64'h0);
    tick();
    Reset = 1'b0;
    chk("rstwr.mem", mem[16'h00FF], 64'hA5A5A5A5_5A5A5A5A);
    chk("rstwr.req_ready", {63'h0, req_ready}, 64'h1);
    chk("rstwr.resp_valid", {63'h0, resp_valid}, 64'h0);
    chk("rstwr.we", {63'h0, WriteEnable}, 64'h0);
    chk("rstwr.xy", {48'h0, X_addr, Y_addr}, 64'h0);
    chk("rstwr.data_in", Data_in, 64'h0);
    chk("rstwr.rdata", resp_rdata, 64'h0);
    v.wr = 1'b0; v.addr = 16'h00FF; v.wdata = 64'h0; v.be = 8'h00;
    v.lat = 3; v.rdata = 64'hA5A5A5A5_5A5A5A5A; v.we_lat = 0; v.we_data = 64'h0;
    run_vec(v, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

endmodule
